// File: rtl/branch_predict_unit.sv
// Branch prediction (2-bit saturating counter table) and execute-stage resolution
// with registered flush/redirect and saturating performance counters.
module branch_predict_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 16,
   parameter logic [1:0]  CNT_INIT    = 2'b01,
   parameter int unsigned PERF_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   pred_pc,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic [XLEN-1:0]   res_pc,
   input  logic [2:0]        res_funct3,
   input  logic              res_pred_taken,
   input  logic [XLEN-1:0]   res_target,
   input  logic [XLEN-1:0]   res_pc_plus4,
   input  logic              cf,
   input  logic              zf,
   input  logic              vf,
   input  logic              sf,
   output logic              br_taken,
   output logic              flush,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              illegal_br,
   output logic [PERF_W-1:0] br_count,
   output logic [PERF_W-1:0] mispred_count
);
   localparam int unsigned IDX = $clog2(BHT_ENTRIES);

   logic [1:0]        bht_q [BHT_ENTRIES];
   logic [IDX-1:0]    pred_idx;
   logic [IDX-1:0]    res_idx;
   logic              cond;
   logic              legal;
   logic              accept;
   logic              br_taken_q, br_taken_d;
   logic              flush_q, flush_d;
   logic              illegal_q, illegal_d;
   logic [XLEN-1:0]   redirect_q, redirect_d;
   logic [PERF_W-1:0] br_count_q, br_count_d;
   logic [PERF_W-1:0] mispred_q, mispred_d;

   assign pred_idx   = pred_pc[IDX+1:2];
   assign res_idx    = res_pc[IDX+1:2];
   assign pred_taken = bht_q[pred_idx][1];

   // The instruction resolving while flush is high is the squashed younger one.
   assign accept = res_valid & ~flush_q;

   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      case (res_funct3)
         3'b000:  cond = zf;
         3'b001:  cond = ~zf;
         3'b100:  cond = sf ^ vf;
         3'b101:  cond = ~(sf ^ vf);
         3'b110:  cond = ~cf;
         3'b111:  cond = cf;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      br_taken_d = 1'b0;
      flush_d    = 1'b0;
      illegal_d  = 1'b0;
      redirect_d = redirect_q;
      br_count_d = br_count_q;
      mispred_d  = mispred_q;
      if (accept) begin
         if (legal) begin
            br_taken_d = cond;
            if (br_count_q != '1) br_count_d = br_count_q + PERF_W'(1);
            if (cond != res_pred_taken) begin
               flush_d    = 1'b1;
               redirect_d = cond ? res_target : res_pc_plus4;
               if (mispred_q != '1) mispred_d = mispred_q + PERF_W'(1);
            end
         end else begin
            illegal_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bht_q      <= '{default: CNT_INIT};
         br_taken_q <= 1'b0;
         flush_q    <= 1'b0;
         illegal_q  <= 1'b0;
         redirect_q <= '0;
         br_count_q <= '0;
         mispred_q  <= '0;
      end else begin
         if (accept && legal) begin
            if (cond && bht_q[res_idx] != 2'b11)
               bht_q[res_idx] <= bht_q[res_idx] + 2'b01;
            else if (!cond && bht_q[res_idx] != 2'b00)
               bht_q[res_idx] <= bht_q[res_idx] - 2'b01;
         end
         br_taken_q <= br_taken_d;
         flush_q    <= flush_d;
         illegal_q  <= illegal_d;
         redirect_q <= redirect_d;
         br_count_q <= br_count_d;
         mispred_q  <= mispred_d;
      end
   end

   assign br_taken      = br_taken_q;
   assign flush         = flush_q;
   assign illegal_br    = illegal_q;
   assign redirect_pc   = redirect_q;
   assign br_count      = br_count_q;
   assign mispred_count = mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: operand-level reference model checked every cycle,
// two instances (PERF_W=16 and PERF_W=4) sharing one stimulus stream.
module tb_branch_predict_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pred_pc = '0;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0, res_target = '0, res_pc_plus4 = '0;
   logic [2:0]  res_funct3 = '0;
   logic        res_pred_taken = 1'b0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        cf, zf, vf, sf;
   logic [32:0] diff;

   logic        pt0, bt0, fl0, il0, pt1, bt1, fl1, il1;
   logic [31:0] rp0, rp1;
   logic [15:0] bc0, mc0;
   logic [3:0]  bc1, mc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Flags as the ALU would produce them from rs1 - rs2.
   assign diff = {1'b0, rs1} - {1'b0, rs2};
   assign cf   = ~diff[32];
   assign zf   = (diff[31:0] == 32'd0);
   assign sf   = diff[31];
   assign vf   = (rs1[31] ^ rs2[31]) & (diff[31] ^ rs1[31]);

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .PERF_W(16)) dut0 (
      .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pt0),
      .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
      .res_pred_taken(res_pred_taken), .res_target(res_target), .res_pc_plus4(res_pc_plus4),
      .cf(cf), .zf(zf), .vf(vf), .sf(sf), .br_taken(bt0), .flush(fl0),
      .redirect_pc(rp0), .illegal_br(il0), .br_count(bc0), .mispred_count(mc0));

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .PERF_W(4)) dut1 (
      .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pt1),
      .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
      .res_pred_taken(res_pred_taken), .res_target(res_target), .res_pc_plus4(res_pc_plus4),
      .cf(cf), .zf(zf), .vf(vf), .sf(sf), .br_taken(bt1), .flush(fl1),
      .redirect_pc(rp1), .illegal_br(il1), .br_count(bc1), .mispred_count(mc1));

   // Reference model: integer counters, comparisons straight from the operands.
   int          m_bht [16];
   bit          m_flush = 1'b0, m_bt = 1'b0, m_ill = 1'b0;
   logic [31:0] m_rp = '0;
   int          m_bc = 0, m_mc = 0;

   function automatic bit outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int idx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd15);
   endfunction

   always @(posedge clk or negedge rst) begin
      bit acc, lgl, o;
      int i;
      if (!rst) begin
         foreach (m_bht[k]) m_bht[k] = 1;
         m_flush = 1'b0; m_bt = 1'b0; m_ill = 1'b0; m_rp = '0; m_bc = 0; m_mc = 0;
      end else begin
         acc = res_valid && !m_flush;
         lgl = !(res_funct3 == 3'b010 || res_funct3 == 3'b011);
         i   = idx(res_pc);
         o   = outcome(res_funct3, rs1, rs2);
         m_bt = 1'b0; m_ill = 1'b0; m_flush = 1'b0;
         if (acc && lgl) begin
            m_bht[i] = o ? sat(m_bht[i] + 1, 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
            m_bt = o;
            m_bc++;
            if (o != res_pred_taken) begin
               m_flush = 1'b1;
               m_rp    = o ? res_target : res_pc_plus4;
               m_mc++;
            end
         end else if (acc) begin
            m_ill = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pred_taken", {31'd0, pt0}, {31'd0, m_bht[idx(pred_pc)] >= 2});
      chk("pred_taken_w4", {31'd0, pt1}, {31'd0, m_bht[idx(pred_pc)] >= 2});
      chk("br_taken", {31'd0, bt0}, {31'd0, m_bt});
      chk("flush", {31'd0, fl0}, {31'd0, m_flush});
      chk("illegal_br", {31'd0, il0}, {31'd0, m_ill});
      chk("redirect_pc", rp0, m_rp);
      chk("br_count", {16'd0, bc0}, 32'(sat(m_bc, 65535)));
      chk("mispred_count", {16'd0, mc0}, 32'(sat(m_mc, 65535)));
      chk("flush_w4", {31'd0, fl1}, {31'd0, m_flush});
      chk("br_count_w4", {28'd0, bc1}, 32'(sat(m_bc, 15)));
      chk("mispred_count_w4", {28'd0, mc1}, 32'(sat(m_mc, 15)));
   end

   task automatic resolve(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input bit pred, input logic [31:0] tgt);
      @(posedge clk); #2;
      res_valid = 1'b1; res_funct3 = f; res_pc = pc; rs1 = a; rs2 = b;
      res_pred_taken = pred; res_target = tgt; res_pc_plus4 = pc + 32'd4;
   endtask

   task automatic idle();
      @(posedge clk); #2;
      res_valid = 1'b0;
   endtask

   typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; bit p; } vec_t;
   vec_t vecs [8] = '{
      '{3'd4, 32'h8000_0000, 32'd1, 1'b0},
      '{3'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0},
      '{3'd6, 32'd3, 32'hFFFF_FFF0, 1'b0},
      '{3'd7, 32'd3, 32'hFFFF_FFF0, 1'b1},
      '{3'd1, 32'd9, 32'd9, 1'b1},
      '{3'd0, 32'd9, 32'd9, 1'b1},
      '{3'd5, 32'hFFFF_FFFE, 32'd2, 1'b1},
      '{3'd3, 32'd1, 32'd1, 1'b0}
   };

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      pred_pc = 32'h40;
      #1 chk("lit_reset_pred", {31'd0, pt0}, 32'd0);

      resolve(3'd0, 32'h40, 32'd5, 32'd5, 1'b0, 32'h80);
      idle();
      #1;
      chk("lit_beq_flush", {31'd0, fl0}, 32'd1);
      chk("lit_beq_redirect", rp0, 32'h80);
      chk("lit_beq_taken", {31'd0, bt0}, 32'd1);
      chk("lit_beq_mispred", {16'd0, mc0}, 32'd1);
      pred_pc = 32'h40;
      #1 chk("lit_trained_pred", {31'd0, pt0}, 32'd1);

      repeat (3) resolve(3'd1, 32'h44, 32'd1, 32'd2, 1'b1, 32'h200);
      resolve(3'd1, 32'h44, 32'd3, 32'd3, 1'b1, 32'h200);
      idle();
      pred_pc = 32'h44;
      #1;
      chk("lit_bne_redirect", rp0, 32'h48);
      chk("lit_bne_pred_after_dec", {31'd0, pt0}, 32'd1);

      resolve(3'd0, 32'h48, 32'd1, 32'd2, 1'b1, 32'h300);
      resolve(3'd0, 32'h48, 32'd3, 32'd3, 1'b0, 32'h300);
      idle();
      #1;
      chk("lit_shadow_flush", {31'd0, fl0}, 32'd0);
      chk("lit_shadow_taken", {31'd0, bt0}, 32'd0);

      resolve(3'd4, 32'h50, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h400);
      idle();
      #1 chk("lit_blt_taken", {31'd0, bt0}, 32'd1);
      resolve(3'd7, 32'h54, 32'd1, 32'd2, 1'b0, 32'h400);
      idle();
      #1 chk("lit_bgeu_flush", {31'd0, fl0}, 32'd0);
      resolve(3'd2, 32'h58, 32'd1, 32'd1, 1'b1, 32'h400);
      idle();
      #1;
      chk("lit_illegal", {31'd0, il0}, 32'd1);
      chk("lit_illegal_flush", {31'd0, fl0}, 32'd0);

      foreach (vecs[k]) begin
         resolve(vecs[k].f, 32'h60 + 32'(k) * 4, vecs[k].a, vecs[k].b, vecs[k].p, 32'h500 + 32'(k));
         pred_pc = 32'h60 + 32'(k) * 4;
         if (k % 2 == 1) idle();
      end
      idle();

      resolve(3'd0, 32'h44, 32'd1, 32'd1, 1'b1, 32'h600);
      @(posedge clk); #3;
      rst = 1'b0;
      res_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pred_pc = 32'(i) * 4;
         #1 chk("lit_midreset_pred", {31'd0, pt0}, 32'd0);
         @(posedge clk); #2;
      end
      chk("lit_midreset_count", {16'd0, bc0}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         resolve(3'd0, 32'h100 + 32'(i) * 4, 32'd7, 32'd7, 1'b0, 32'h700);
         idle();
      end
      #1;
      chk("lit_sat_br_w4", {28'd0, bc1}, 32'd15);
      chk("lit_sat_mis_w4", {28'd0, mc1}, 32'd15);
      chk("lit_br_w16", {16'd0, bc0}, 32'd20);
      chk("lit_mis_w16", {16'd0, mc0}, 32'd20);

      repeat (2) idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
